// File: rtl/io_port_ctrl_pkg.sv
// rtl/io_port_ctrl_pkg.sv - opcodes, command word fields and status word layout for io_port_controller
package io_port_ctrl_pkg;

    localparam logic [3:0] OP_NOP        = 4'd0;
    localparam logic [3:0] OP_READ       = 4'd1;
    localparam logic [3:0] OP_WRITE      = 4'd2;
    localparam logic [3:0] OP_RELEASE    = 4'd3;
    localparam logic [3:0] OP_CAPTURE_ON = 4'd4;
    localparam logic [3:0] OP_POP        = 4'd5;
    localparam logic [3:0] OP_STATUS     = 4'd6;
    localparam logic [3:0] OP_CLEAR      = 4'd7;

    localparam int CMD_OP_LSB     = 0;
    localparam int CMD_OP_WIDTH   = 4;
    localparam int CMD_PORT_LSB   = 4;
    localparam int CMD_PORT_WIDTH = 4;

    localparam int ST_OE_LSB = 0;

    // Status word: oe, cap, empty, overflow, error, then FIFO count.
    function automatic int st_cap_lsb(input int num_ports);
        return num_ports;
    endfunction

    function automatic int st_empty_bit(input int num_ports);
        return 2 * num_ports;
    endfunction

    function automatic int st_ovf_bit(input int num_ports);
        return 2 * num_ports + 1;
    endfunction

    function automatic int st_err_bit(input int num_ports);
        return 2 * num_ports + 2;
    endfunction

    function automatic int st_count_lsb(input int num_ports);
        return 2 * num_ports + 3;
    endfunction

endpackage

// File: rtl/io_capture_fifo.sv
// rtl/io_capture_fifo.sv - capture FIFO with flush; a pop frees a slot for a same-cycle push when full
module io_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - multi-port IO controller: holding register, port commands, shared capture FIFO
// Optional IO_PORT_CTRL_SYNC_EN: 2-flop synchronisers on io_bus inputs and io_strobe.
module io_port_controller
    import io_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PORT_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    inout  wire  [DATA_WIDTH-1:0]           bus,
    input  logic [2:0]                      io_control_bus,
    inout  wire  [NUM_PORTS*PORT_WIDTH-1:0] io_bus,
    input  logic [NUM_PORTS-1:0]            io_strobe,
    output logic [7:0]                      io_command_bus,
    output logic [PORT_WIDTH-1:0]           io_register
);

    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PORT_BITS = NUM_PORTS * PORT_WIDTH;
    localparam int ST_CAP    = st_cap_lsb(NUM_PORTS);
    localparam int ST_EMPTY  = st_empty_bit(NUM_PORTS);
    localparam int ST_OVF    = st_ovf_bit(NUM_PORTS);
    localparam int ST_ERR    = st_err_bit(NUM_PORTS);
    localparam int ST_CNT    = st_count_lsb(NUM_PORTS);
    localparam logic [CMD_PORT_WIDTH:0] PORT_LIMIT = (CMD_PORT_WIDTH + 1)'(NUM_PORTS);

    if (ST_CNT + CNT_W > DATA_WIDTH || PORT_WIDTH > DATA_WIDTH ||
        NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_params
        $error("io_port_controller: parameter combination does not fit the status word");
    end

    logic [DATA_WIDTH-1:0]                hold;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] out_reg;
    logic [NUM_PORTS-1:0]                 oe;
    logic [NUM_PORTS-1:0]                 cap;
    logic                                 overflow;
    logic                                 error_flag;
    logic [7:0]                           cmd_pulse;

    logic [PORT_BITS-1:0]                 port_in_flat;
    logic [NUM_PORTS-1:0]                 strobe_in;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] port_in;

`ifdef IO_PORT_CTRL_SYNC_EN
    logic [PORT_BITS-1:0] port_meta;
    logic [PORT_BITS-1:0] port_sync;
    logic [NUM_PORTS-1:0] strobe_meta;
    logic [NUM_PORTS-1:0] strobe_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            port_meta   <= '0;
            port_sync   <= '0;
            strobe_meta <= '0;
            strobe_sync <= '0;
        end else begin
            port_meta   <= io_bus;
            port_sync   <= port_meta;
            strobe_meta <= io_strobe;
            strobe_sync <= strobe_meta;
        end
    end

    assign port_in_flat = port_sync;
    assign strobe_in    = strobe_sync;
`else
    assign port_in_flat = io_bus;
    assign strobe_in    = io_strobe;
`endif

    assign port_in = port_in_flat;

    logic [DATA_WIDTH-1:0]     bus_in;
    logic [CMD_OP_WIDTH-1:0]   opcode;
    logic [CMD_PORT_WIDTH-1:0] port_idx;
    logic [IDX_W-1:0]          port_sel;

    assign bus_in   = bus;
    assign opcode   = bus_in[CMD_OP_LSB +: CMD_OP_WIDTH];
    assign port_idx = bus_in[CMD_PORT_LSB +: CMD_PORT_WIDTH];
    assign port_sel = port_idx[IDX_W-1:0];

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [PORT_WIDTH-1:0] fifo_head;

    // A command presented together with a load is discarded (load wins).
    logic cmd_strobe;
    logic uses_port;
    logic cmd_legal;
    logic do_pop;
    logic do_flush;

    assign cmd_strobe = io_control_bus[2] & ~io_control_bus[0];
    assign uses_port  = (opcode >= OP_READ) && (opcode <= OP_CAPTURE_ON);
    assign cmd_legal  = (opcode <= OP_CLEAR)
                      && !(uses_port && ({1'b0, port_idx} >= PORT_LIMIT))
                      && !((opcode == OP_POP) && fifo_empty);
    assign do_pop     = cmd_strobe & cmd_legal & (opcode == OP_POP);
    assign do_flush   = cmd_strobe & cmd_legal & (opcode == OP_CLEAR);

    logic [NUM_PORTS-1:0] qual;
    logic [IDX_W-1:0]     push_idx;
    logic                 cap_multi;
    logic                 fifo_push;
    logic                 push_drop;

    assign qual      = cap & strobe_in;
    assign cap_multi = |(qual & (qual - NUM_PORTS'(1)));
    assign fifo_push = (|qual) & ~do_flush;
    assign push_drop = fifo_push & fifo_full & ~do_pop;

    // Lowest-index qualified port wins the single push slot per cycle.
    always_comb begin
        push_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                push_idx = IDX_W'(i);
            end
        end
    end

    io_capture_fifo #(
        .WIDTH (PORT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (port_in[push_idx]),
        .pop       (do_pop),
        .flush     (do_flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    logic [DATA_WIDTH-1:0] status_word;

    always_comb begin
        status_word = '0;
        status_word[ST_OE_LSB +: NUM_PORTS] = oe;
        status_word[ST_CAP +: NUM_PORTS]    = cap;
        status_word[ST_EMPTY]               = fifo_empty;
        status_word[ST_OVF]                 = overflow;
        status_word[ST_ERR]                 = error_flag;
        status_word[ST_CNT +: CNT_W]        = fifo_count;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold       <= '0;
            out_reg    <= '0;
            oe         <= '0;
            cap        <= '0;
            overflow   <= 1'b0;
            error_flag <= 1'b0;
            cmd_pulse  <= '0;
        end else begin
            cmd_pulse <= '0;
            if (cap_multi || push_drop) begin
                overflow <= 1'b1;
            end
            if (io_control_bus[0]) begin
                hold <= bus_in;
                if (io_control_bus[2]) begin
                    error_flag <= 1'b1;
                end
            end else if (io_control_bus[2]) begin
                if (!cmd_legal) begin
                    error_flag <= 1'b1;
                end else begin
                    cmd_pulse <= 8'b1 << opcode[2:0];
                    case (opcode)
                        OP_NOP: ;
                        OP_READ:       hold <= DATA_WIDTH'(port_in[port_sel]);
                        OP_WRITE: begin
                            out_reg[port_sel] <= hold[PORT_WIDTH-1:0];
                            oe[port_sel]      <= 1'b1;
                        end
                        OP_RELEASE:    oe[port_sel]  <= 1'b0;
                        OP_CAPTURE_ON: cap[port_sel] <= 1'b1;
                        OP_POP:        hold <= DATA_WIDTH'(fifo_head);
                        OP_STATUS:     hold <= status_word;
                        OP_CLEAR: begin
                            overflow   <= 1'b0;
                            error_flag <= 1'b0;
                            cap        <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign io_bus[p*PORT_WIDTH +: PORT_WIDTH] = oe[p] ? out_reg[p] : {PORT_WIDTH{1'bz}};
    end

    assign bus            = io_control_bus[1] ? hold : {DATA_WIDTH{1'bz}};
    assign io_register    = hold[PORT_WIDTH-1:0];
    assign io_command_bus = cmd_pulse;

endmodule
